op_encoder: RTL and testbench
=============================

// Module: op_encoder
// PURPOSE
//  Front end for the clock's control path. Synchronises and debounces three raw push-buttons
//  (minute-add, stop/zero, reset) and encodes them onto the 2-bit operation bus read by the
//  seconds-pulse block. Holds each operation until that block returns its ack (res), then
//  releases the bus: a 4-phase req/ack handshake. Sits between board buttons and sec_pulse.
// PARAMETERS
//  DB_CYCLES   1000000   consecutive stable clk cycles to accept a button level (20 ms @ 50 MHz)
//  CNT_W       20        width of each debounce counter; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//  clk         in   1  system clock, 50 MHz
//  reset       in   1  asynchronous, active-high reset
//  btn_madd    in   1  raw minute-add button, active-high, asynchronous to clk
//  btn_sto0    in   1  raw stop/zero button, active-high, asynchronous to clk
//  btn_res     in   1  raw reset button, active-high, asynchronous to clk
//  ack         in   1  acknowledge from sec_pulse (its res output), level, synchronous to clk
//  operation   out  2  00 nor, 01 sto0, 10 madd, 11 res
//  busy        out  1  high while a handshake is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: operation=00, busy=0, all sync flops/debounced levels=0, counters=0, pending=00,
//   state=IDLE. Reset asserted mid-handshake aborts it immediately; no op reissued after release.
//  Sync: each button passes through a 2-flop synchroniser (s1->s2).
//  Debounce, per button: if s2 == db_level, counter clears to 0; otherwise counter increments.
//   When the counter reaches DB_CYCLES-1 while s2 != db_level, db_level <= s2 and counter <= 0.
//   Glitches shorter than DB_CYCLES cycles never change db_level.
//  Press event: db_level rising edge (registered previous level), one clk wide. Release = no event.
//  Priority when events coincide in one cycle: res(11) > sto0(01) > madd(10).
//  pending[1:0]: one-deep latch. In IDLE, an event writes its code unless pending already holds
//   a higher-priority code. In ISSUE/WAIT_REL, events are dropped (not latched).
//  FSM:
//   IDLE:     operation=00. If (pending!=00 or event) and ack==0: operation<=code, pending<=00,
//             -> ISSUE. Same-cycle event with empty pending issues directly.
//             If ack==1: hold the request in pending and stay.
//   ISSUE:    operation held at code. On ack==1: operation<=00 -> WAIT_REL. No timeout.
//   WAIT_REL: operation=00. On ack==0 -> IDLE.
//  busy = (state != IDLE); registered, changes on the same edge as state.
//  Latency: a raw button held high is seen on operation exactly DB_CYCLES+4 clk after its first
//   sampled-high edge (2 sync + DB_CYCLES debounce + 1 edge detect + 1 FSM), given IDLE, ack=0.
//  ack to release: operation returns to 00 on the first clk edge after ack is sampled high.
//  Holding a button never auto-repeats; a new operation needs release + re-press, each >= DB_CYCLES.
//  All outputs registered; no combinational path from any input to any output.
// TESTING  (DB_CYCLES=4, CNT_W=3)
//  1 Reset: assert reset with buttons high -> operation=00, busy=0 during reset and one clk after release.
//  2 Clean press: btn_madd high 20 clk, ack=0 -> operation=10 exactly 8 clk after first sample;
//    ack high 3 clk later -> operation=00 next clk; ack low -> busy=0 next clk; no repeat.
//  3 Bounce: btn_sto0 toggled every 2 clk for 16 clk, then low -> operation stays 00 throughout.
//  4 Simultaneous: btn_madd and btn_res rise on the same edge -> operation=11; madd never issued.
//  5 Pending/ack-high: ack held high, press btn_madd then btn_res -> pending=11; drop ack ->
//    operation=11 next clk; a btn_sto0 press during ISSUE is dropped (no 01 after handshake).
//  6 Reset mid-handshake: in ISSUE with operation=01, pulse reset -> operation=00, state IDLE,
//    no re-issue after reset while button still held.

Source files
------------

// File: rtl/op_encoder.sv
// Button front end for the clock control path: synchronise, debounce and edge-detect three
// push-buttons, then issue one operation code at a time over a 4-phase req/ack handshake.
module op_encoder #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_madd,
  input  logic       btn_sto0,
  input  logic       btn_res,
  input  logic       ack,
  output logic [1:0] operation,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] OP_NOR  = 2'b00;
  localparam logic [1:0] OP_STO0 = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_RES  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_REL
  } state_t;

  // Bit order for all per-button vectors: [0]=madd, [1]=sto0, [2]=res.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       db;
  logic [2:0]       db_prev;
  logic [2:0]       ev;
  logic [2:0]       armed;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt [3];

  state_t     state;
  logic [1:0] pending;
  logic [1:0] ev_code;
  logic [1:0] merged;

  assign raw = {btn_res, btn_sto0, btn_madd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      settle <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      settle <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A button still held across reset must be seen low (once the synchroniser has refilled)
  // before its next press counts, so a reset never re-issues the operation it aborted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed   <= '0;
      db_prev <= '0;
      ev      <= '0;
    end else begin
      armed   <= armed | ({3{settle[1]}} & ~s2);
      db_prev <= db;
      ev      <= db & ~db_prev & armed;
    end
  end

  function automatic logic [1:0] rank(input logic [1:0] code);
    case (code)
      OP_RES:  rank = 2'd3;
      OP_STO0: rank = 2'd2;
      OP_MADD: rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  always_comb begin
    ev_code = OP_NOR;
    if (ev[2]) begin
      ev_code = OP_RES;
    end else if (ev[1]) begin
      ev_code = OP_STO0;
    end else if (ev[0]) begin
      ev_code = OP_MADD;
    end
  end

  always_comb begin
    merged = pending;
    if (rank(ev_code) > rank(pending)) begin
      merged = ev_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      operation <= OP_NOR;
      busy      <= 1'b0;
      pending   <= OP_NOR;
    end else begin
      case (state)
        IDLE: begin
          if (merged != OP_NOR) begin
            if (!ack) begin
              operation <= merged;
              pending   <= OP_NOR;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              pending <= merged;
            end
          end
        end
        ISSUE: begin
          if (ack) begin
            operation <= OP_NOR;
            state     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          operation <= OP_NOR;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_encoder.sv
// Directed bench for op_encoder with a short debounce window (DB_CYCLES=4).
module tb_op_encoder;

  logic       clk;
  logic       reset;
  logic       btn_madd;
  logic       btn_sto0;
  logic       btn_res;
  logic       ack;
  logic [1:0] operation;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  op_encoder #(
    .DB_CYCLES(4),
    .CNT_W    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_madd (btn_madd),
    .btn_sto0 (btn_sto0),
    .btn_res  (btn_res),
    .ack      (ack),
    .operation(operation),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_op(input string tag, input logic [1:0] exp);
    checks++;
    assert (operation === exp) else begin
      failures++;
      $error("FAIL %s operation observed=%b expected=%b", tag, operation, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input logic exp);
    checks++;
    assert (busy === exp) else begin
      failures++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk_op(tag, 2'b00);
    end
  endtask

  initial begin
    // 1: reset with all buttons held
    reset = 1'b1; btn_madd = 1'b1; btn_sto0 = 1'b1; btn_res = 1'b1; ack = 1'b0;
    #1;
    chk_op("rst_async_op", 2'b00);
    chk_busy("rst_async_busy", 1'b0);
    repeat (3) tick();
    chk_op("rst_hold_op", 2'b00);
    reset = 1'b0;
    tick();
    chk_op("rst_rel_op", 2'b00);
    chk_busy("rst_rel_busy", 1'b0);
    quiet("rst_held_btn", 10);
    btn_madd = 1'b0; btn_sto0 = 1'b0; btn_res = 1'b0;
    quiet("rst_btn_release", 12);

    // 2: clean madd press, exact latency and handshake
    btn_madd = 1'b1;
    repeat (7) tick();
    chk_op("madd_lat_minus1", 2'b00);
    tick();
    chk_op("madd_lat", 2'b10);
    chk_busy("madd_busy", 1'b1);
    repeat (3) tick();
    chk_op("madd_hold", 2'b10);
    ack = 1'b1;
    tick();
    chk_op("madd_ack_release", 2'b00);
    chk_busy("madd_wait_rel_busy", 1'b1);
    ack = 1'b0;
    tick();
    chk_busy("madd_idle_busy", 1'b0);
    quiet("madd_no_repeat", 7);
    btn_madd = 1'b0;
    quiet("madd_release", 10);

    // 3: bouncing sto0 never debounces
    for (int k = 0; k < 8; k++) begin
      btn_sto0 = ~btn_sto0;
      quiet("bounce", 2);
    end
    btn_sto0 = 1'b0;
    quiet("bounce_after", 10);
    chk_busy("bounce_busy", 1'b0);

    // 4: madd and res together, res wins
    btn_madd = 1'b1; btn_res = 1'b1;
    repeat (8) tick();
    chk_op("simul_res", 2'b11);
    ack = 1'b1;
    tick();
    chk_op("simul_ack", 2'b00);
    ack = 1'b0;
    tick();
    chk_busy("simul_idle", 1'b0);
    quiet("simul_no_madd", 4);
    btn_madd = 1'b0; btn_res = 1'b0;
    quiet("simul_release", 10);

    // 5: events latched while ack high, higher priority replaces pending
    ack = 1'b1;
    btn_madd = 1'b1;
    quiet("pend_madd", 10);
    btn_madd = 1'b0;
    quiet("pend_gap", 2);
    btn_res = 1'b1;
    quiet("pend_res", 10);
    chk_busy("pend_idle_busy", 1'b0);
    btn_res = 1'b0;
    quiet("pend_release", 8);
    ack = 1'b0;
    tick();
    chk_op("pend_issue", 2'b11);
    chk_busy("pend_issue_busy", 1'b1);
    btn_sto0 = 1'b1;
    repeat (10) tick();
    btn_sto0 = 1'b0;
    repeat (8) tick();
    chk_op("pend_drop_hold", 2'b11);
    ack = 1'b1;
    tick();
    chk_op("pend_ack", 2'b00);
    ack = 1'b0;
    tick();
    chk_busy("pend_done", 1'b0);
    quiet("pend_no_sto0", 12);

    // 6: reset aborts a handshake, held button not re-issued
    btn_sto0 = 1'b1;
    repeat (8) tick();
    chk_op("midrst_issue", 2'b01);
    reset = 1'b1;
    #1;
    chk_op("midrst_async_op", 2'b00);
    chk_busy("midrst_async_busy", 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_op("midrst_no_reissue", 2'b00);
      chk_busy("midrst_no_busy", 1'b0);
    end
    btn_sto0 = 1'b0;
    quiet("midrst_release", 10);
    btn_sto0 = 1'b1;
    repeat (7) tick();
    chk_op("repress_lat_minus1", 2'b00);
    tick();
    chk_op("repress_sto0", 2'b01);
    ack = 1'b1;
    tick();
    chk_op("repress_ack", 2'b00);
    ack = 1'b0;
    btn_sto0 = 1'b0;
    tick();
    chk_busy("repress_done", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
